// File: rtl/iram_arb.sv
// rtl/iram_arb.sv - single-port IRAM arbiter between IFU fetch and loader/debug port
//
// Purpose: grants one IRAM access per cycle to either the IFU fetch path or the
// loader port, stalls the IFU (pc_wr_en_o) when it loses the RAM, returns NOP
// bubbles on the fetch path and bounds loader bursts to MAX_BURST grants.
//
// Ports:
//   clk_i, rst_i                    clock, synchronous active-high reset
//   halt_i                          debug halt (IFU starved, burst limit ignored)
//   if_addr_i / pc_wr_en_o / if_data_o                 IFU fetch port
//   ldr_req_i, ldr_wr_i, ldr_addr_i, ldr_wdata_i, ldr_wbe_i,
//   ldr_gnt_o, ldr_rvalid_o, ldr_rdata_o               loader port
//   iram_addr_o, iram_wr_en_o, iram_wbe_o, iram_wr_data_o, iram_rd_data_i
//                                   single-port IRAM, 1-cycle synchronous read
module iram_arb #(
    parameter int XLEN      = 32,
    parameter int ADDR_W    = 10,
    parameter int MAX_BURST = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                halt_i,
    input  logic [XLEN-1:0]     if_addr_i,
    output logic                pc_wr_en_o,
    output logic [XLEN-1:0]     if_data_o,
    input  logic                ldr_req_i,
    input  logic                ldr_wr_i,
    input  logic [XLEN-1:0]     ldr_addr_i,
    input  logic [XLEN-1:0]     ldr_wdata_i,
    input  logic [XLEN/8-1:0]   ldr_wbe_i,
    output logic                ldr_gnt_o,
    output logic                ldr_rvalid_o,
    output logic [XLEN-1:0]     ldr_rdata_o,
    output logic [ADDR_W-1:0]   iram_addr_o,
    output logic                iram_wr_en_o,
    output logic [XLEN/8-1:0]   iram_wbe_o,
    output logic [XLEN-1:0]     iram_wr_data_o,
    input  logic [XLEN-1:0]     iram_rd_data_i
);

    localparam logic [XLEN-1:0] NOP     = XLEN'(32'h0000_0013);
    localparam int              CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_LDR   = 2'd1,
        ST_YIELD = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic             if_owned_q, if_owned_d;
    logic             rd_pend_q, rd_pend_d;
    logic [XLEN-1:0]  rdata_q, rdata_d;

    logic             ifu_own, ldr_own;
    logic             ifu_gnt, ldr_gnt;
    logic             run_arb;

    // Address bits outside the IRAM word index are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr_i[XLEN-1:ADDR_W+2], if_addr_i[1:0],
                                ldr_addr_i[XLEN-1:ADDR_W+2], ldr_addr_i[1:0]};

    // RUN and YIELD arbitrate identically: the forced IFU slot is the cycle
    // that leaves LDR for YIELD, so in YIELD a waiting loader starts a fresh
    // burst immediately. HALT with halt_i released also behaves like RUN.
    assign run_arb = (state_q == ST_RUN) || (state_q == ST_YIELD) ||
                     ((state_q == ST_HALT) && !halt_i);

    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        ifu_own     = 1'b0;
        ldr_own     = 1'b0;
        if (run_arb) begin
            burst_cnt_d = '0;
            if (ldr_req_i) begin
                ldr_own     = 1'b1;
                burst_cnt_d = CNT_W'(1);
                state_d     = ST_LDR;
            end else if (halt_i) begin
                state_d = ST_HALT;
            end else begin
                ifu_own = 1'b1;
                state_d = ST_RUN;
            end
        end else if (state_q == ST_LDR) begin
            if (ldr_req_i && ((burst_cnt_q < CNT_MAX) || halt_i)) begin
                ldr_own = 1'b1;
                if (burst_cnt_q < CNT_MAX) begin
                    burst_cnt_d = burst_cnt_q + CNT_W'(1);
                end
            end else if (ldr_req_i) begin
                ifu_own     = 1'b1;
                burst_cnt_d = '0;
                state_d     = ST_YIELD;
            end else begin
                burst_cnt_d = '0;
                if (halt_i) begin
                    state_d = ST_HALT;
                end else begin
                    ifu_own = 1'b1;
                    state_d = ST_RUN;
                end
            end
        end else begin
            // HALT with halt_i held: loader served on demand, IFU starved.
            ldr_own     = ldr_req_i;
            burst_cnt_d = '0;
        end
    end

    // Reset masks every grant in the same cycle so no access leaks out while
    // the registers still hold pre-reset state.
    assign ifu_gnt = ifu_own & ~rst_i;
    assign ldr_gnt = ldr_own & ~rst_i;

    assign pc_wr_en_o     = ifu_gnt;
    assign ldr_gnt_o      = ldr_gnt;
    assign iram_addr_o    = ldr_gnt ? ldr_addr_i[ADDR_W+1:2] : if_addr_i[ADDR_W+1:2];
    assign iram_wr_en_o   = ldr_gnt & ldr_wr_i;
    assign iram_wbe_o     = iram_wr_en_o ? ldr_wbe_i : '0;
    assign iram_wr_data_o = iram_wr_en_o ? ldr_wdata_i : '0;

    assign if_data_o    = (if_owned_q && !rst_i) ? iram_rd_data_i : NOP;
    assign ldr_rvalid_o = rd_pend_q & ~rst_i;
    assign ldr_rdata_o  = rst_i     ? '0 :
                          rd_pend_q ? iram_rd_data_i : rdata_q;

    always_comb begin
        if_owned_d = ifu_gnt;
        rd_pend_d  = ldr_gnt & ~ldr_wr_i;
        rdata_d    = rd_pend_q ? iram_rd_data_i : rdata_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_RUN;
            burst_cnt_q <= '0;
            if_owned_q  <= 1'b0;
            rd_pend_q   <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            if_owned_q  <= if_owned_d;
            rd_pend_q   <= rd_pend_d;
            rdata_q     <= rdata_d;
        end
    end

endmodule

// File: tb/tb_iram_arb.sv
// tb/tb_iram_arb.sv - directed self-checking bench for iram_arb
module tb_iram_arb;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, halt;
    logic [31:0] if_addr, if_data;
    logic        pc_wr_en;
    logic        ldr_req, ldr_wr, ldr_gnt, ldr_rvalid;
    logic [31:0] ldr_addr, ldr_wdata, ldr_rdata;
    logic [3:0]  ldr_wbe, iram_wbe;
    logic [9:0]  iram_addr;
    logic        iram_wr_en;
    logic [31:0] iram_wr_data, iram_rd_data;

    logic [31:0] mem [0:1023];
    logic [31:0] prog [4] = '{32'h0000_0093, 32'h0010_0113, 32'h0080_006F, 32'h0020_0193};
    int          pat3 [12] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1};

    int total = 0;
    int bad   = 0;

    iram_arb #(.XLEN(32), .ADDR_W(10), .MAX_BURST(4)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .halt_i         (halt),
        .if_addr_i      (if_addr),
        .pc_wr_en_o     (pc_wr_en),
        .if_data_o      (if_data),
        .ldr_req_i      (ldr_req),
        .ldr_wr_i       (ldr_wr),
        .ldr_addr_i     (ldr_addr),
        .ldr_wdata_i    (ldr_wdata),
        .ldr_wbe_i      (ldr_wbe),
        .ldr_gnt_o      (ldr_gnt),
        .ldr_rvalid_o   (ldr_rvalid),
        .ldr_rdata_o    (ldr_rdata),
        .iram_addr_o    (iram_addr),
        .iram_wr_en_o   (iram_wr_en),
        .iram_wbe_o     (iram_wbe),
        .iram_wr_data_o (iram_wr_data),
        .iram_rd_data_i (iram_rd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (iram_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (iram_wbe[b]) mem[iram_addr][8*b +: 8] <= iram_wr_data[8*b +: 8];
            end
        end
        iram_rd_data <= mem[iram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; halt = 1'b0; if_addr = '0;
        ldr_req = 1'b0; ldr_wr = 1'b0; ldr_addr = '0; ldr_wdata = '0; ldr_wbe = '0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        for (int i = 0; i < 4; i++) mem[i] = prog[i];

        // reset values
        tick(); tick(); mid();
        chk("rst_pc_wr_en", {31'b0, pc_wr_en}, 32'd0);
        chk("rst_if_data", if_data, NOP);
        chk("rst_gnt", {31'b0, ldr_gnt}, 32'd0);
        chk("rst_rvalid", {31'b0, ldr_rvalid}, 32'd0);
        chk("rst_rdata", ldr_rdata, 32'd0);
        chk("rst_wr_en", {31'b0, iram_wr_en}, 32'd0);
        chk("rst_wbe", {28'b0, iram_wbe}, 32'd0);

        // 1: plain fetch stream
        tick(); rst = 1'b0; if_addr = 32'h0; mid();
        chk("t1_pc_wr_en", {31'b0, pc_wr_en}, 32'd1);
        chk("t1_first_nop", if_data, NOP);
        for (int i = 1; i <= 4; i++) begin
            tick(); if_addr = 32'((i % 4) * 4); mid();
            chk("t1_pc_wr_en_n", {31'b0, pc_wr_en}, 32'd1);
            chk("t1_fetch", if_data, prog[i-1]);
        end

        // 2: loader write then read of word 1
        tick(); ldr_req = 1'b1; ldr_wr = 1'b1; ldr_addr = 32'h4;
        ldr_wdata = 32'h0100_026F; ldr_wbe = 4'hF; mid();
        chk("t2_wr_gnt", {31'b0, ldr_gnt}, 32'd1);
        chk("t2_wr_pc", {31'b0, pc_wr_en}, 32'd0);
        chk("t2_wr_en", {31'b0, iram_wr_en}, 32'd1);
        chk("t2_wr_addr", {22'b0, iram_addr}, 32'd1);
        tick(); ldr_wr = 1'b0; mid();
        chk("t2_rd_gnt", {31'b0, ldr_gnt}, 32'd1);
        chk("t2_rd_pc", {31'b0, pc_wr_en}, 32'd0);
        chk("t2_rd_wr_en", {31'b0, iram_wr_en}, 32'd0);
        chk("t2_bubble", if_data, NOP);
        tick(); ldr_req = 1'b0; if_addr = 32'h0; mid();
        chk("t2_rvalid", {31'b0, ldr_rvalid}, 32'd1);
        chk("t2_rdata", ldr_rdata, 32'h0100_026F);
        chk("t2_pc_back", {31'b0, pc_wr_en}, 32'd1);
        tick(); mid();
        chk("t2_rvalid_off", {31'b0, ldr_rvalid}, 32'd0);
        chk("t2_rdata_hold", ldr_rdata, 32'h0100_026F);
        chk("t2_fetch", if_data, 32'h0000_0093);

        // 3: held loader request, burst limit 4
        for (int i = 0; i < 12; i++) begin
            tick(); ldr_req = 1'b1; ldr_wr = 1'b0; ldr_addr = 32'h10; if_addr = 32'h8; mid();
            chk("t3_gnt", {31'b0, ldr_gnt}, 32'(pat3[i]));
            chk("t3_pc", {31'b0, pc_wr_en}, 32'(1 - pat3[i]));
            if (i > 0) begin
                chk("t3_if_data", if_data, (pat3[i-1] == 1) ? NOP : 32'h0080_006F);
                chk("t3_rvalid", {31'b0, ldr_rvalid}, 32'(pat3[i-1]));
            end
        end
        tick(); ldr_req = 1'b0; mid();
        chk("t3_end_pc", {31'b0, pc_wr_en}, 32'd1);
        chk("t3_end_nop", if_data, NOP);
        chk("t3_end_rvalid", {31'b0, ldr_rvalid}, 32'd1);

        // 4: halt lets the loader run past the burst limit
        for (int i = 0; i < 10; i++) begin
            tick(); halt = 1'b1; ldr_req = 1'b1; mid();
            chk("t4_gnt", {31'b0, ldr_gnt}, 32'd1);
            chk("t4_pc", {31'b0, pc_wr_en}, 32'd0);
        end
        tick(); halt = 1'b0; ldr_req = 1'b0; mid();
        chk("t4_release_pc", {31'b0, pc_wr_en}, 32'd1);

        // 5: byte-lane write over a NOP word
        tick(); ldr_req = 1'b1; ldr_wr = 1'b1; ldr_addr = 32'h8;
        ldr_wdata = 32'h0000_0013; ldr_wbe = 4'hF; mid();
        chk("t5_full_gnt", {31'b0, ldr_gnt}, 32'd1);
        tick(); ldr_wdata = 32'hFFFF_FFFF; ldr_wbe = 4'b0010; mid();
        chk("t5_wbe", {28'b0, iram_wbe}, 32'h2);
        tick(); ldr_wr = 1'b0; ldr_wbe = 4'h0; mid();
        chk("t5_rd_gnt", {31'b0, ldr_gnt}, 32'd1);
        tick(); ldr_req = 1'b0; mid();
        chk("t5_rvalid", {31'b0, ldr_rvalid}, 32'd1);
        chk("t5_rdata", ldr_rdata, 32'h0000_FF13);

        // 6: reset cutting off an in-flight read, address aliasing
        tick(); ldr_req = 1'b1; ldr_wr = 1'b0; ldr_addr = 32'h1004; mid();
        chk("t6_gnt", {31'b0, ldr_gnt}, 32'd1);
        chk("t6_alias", {22'b0, iram_addr}, 32'd1);
        tick(); rst = 1'b1; ldr_req = 1'b0; mid();
        chk("t6_rst_rvalid", {31'b0, ldr_rvalid}, 32'd0);
        chk("t6_rst_pc", {31'b0, pc_wr_en}, 32'd0);
        chk("t6_rst_gnt", {31'b0, ldr_gnt}, 32'd0);
        chk("t6_rst_if_data", if_data, NOP);
        chk("t6_rst_rdata", ldr_rdata, 32'd0);
        tick(); rst = 1'b0; if_addr = 32'h1004; mid();
        chk("t6_post_rvalid", {31'b0, ldr_rvalid}, 32'd0);
        chk("t6_post_rdata", ldr_rdata, 32'd0);
        chk("t6_post_pc", {31'b0, pc_wr_en}, 32'd1);
        chk("t6_if_alias", {22'b0, iram_addr}, 32'd1);
        tick(); mid();
        chk("t6_fetch_alias", if_data, 32'h0100_026F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
